// File: rtl/main_mem_mp_pkg.sv
// Shared widths, defaults and types for the multi-port line memory.
// Port indices are carried at the widest supported size (8 ports) and truncated locally.
package main_mem_mp_pkg;

    localparam int MAIN_MEM_AW     = 8;
    localparam int MAIN_MEM_DW     = 64;
    localparam int N_PORTS_DEFAULT = 2;
    localparam int RD_LAT_DEFAULT  = 1;
    localparam int MAX_PORTS       = 8;

    typedef logic [MAIN_MEM_AW-1:0] line_addr_t;
    typedef logic [MAIN_MEM_DW-1:0] line_data_t;
    typedef logic [2:0]             port_idx_t;

    // Read tracking: which port is owed a response, and for which line.
    typedef struct packed {
        logic       valid;
        port_idx_t  pid;
        line_addr_t addr;
    } rd_trk_t;

    // Write tracking: drives the ack and keeps the data for same-cycle forwarding.
    typedef struct packed {
        logic       valid;
        port_idx_t  pid;
        line_addr_t addr;
        line_data_t data;
    } wr_trk_t;

    function automatic port_idx_t onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dp_ram_clk.sv
// Dual-port line RAM: port A is a synchronous read, port B a synchronous write.
// A same-address collision returns the old contents on port A.
module dp_ram_clk #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          cyc_a_i,
    input  logic [AW-1:0] addr_a_i,
    output logic [DW-1:0] dout_a_o,
    input  logic          cyc_b_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] din_b_i
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

`ifndef SYNTHESIS
    initial begin
        // Zero image.
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
`endif

    // NOTE: the storage array has no reset; contents survive rst and only the control state clears.
    always_ff @(posedge clk) begin
        if (cyc_a_i) dout_a_o <= mem[addr_a_i];
        if (cyc_b_i && we_b_i) mem[addr_b_i] <= din_b_i;
    end

endmodule

// File: rtl/main_mem_mp_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer; the search begins one past the pointer.
// The pointer resets to N-1 so that port 0 has first priority.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  pick;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        req_hi = '0;
        for (int j = 0; j < N; j++) begin
            req_hi[j] = req_i[j] && (j > int'(ptr_q));
        end
        // Requests above the pointer win; otherwise wrap around to the lowest index.
        pick  = (req_hi != '0) ? req_hi : req_i;
        gnt_o = '0;
        ptr_d = ptr_q;
        for (int j = N - 1; j >= 0; j--) begin
            if (pick[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                ptr_d    = PW'(j);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/main_mem_mp.sv
// Multi-port line memory: N request channels, separate read/write round-robin arbiters,
// fixed read latency with write-first forwarding and a one-cycle write acknowledge.
module main_mem_mp
    import main_mem_mp_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEFAULT,
    parameter int RD_LAT  = RD_LAT_DEFAULT,
    parameter int PID_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_PORTS-1:0]                  rd_valid_i,
    input  logic [N_PORTS-1:0][MAIN_MEM_AW-1:0] rd_addr_i,
    output logic [N_PORTS-1:0]                  rd_ready_o,
    output logic [N_PORTS-1:0]                  rd_rsp_valid_o,
    output logic [MAIN_MEM_DW-1:0]              rd_rsp_data_o,
    input  logic [N_PORTS-1:0]                  wr_valid_i,
    input  logic [N_PORTS-1:0][MAIN_MEM_AW-1:0] wr_addr_i,
    input  logic [N_PORTS-1:0][MAIN_MEM_DW-1:0] wr_data_i,
    output logic [N_PORTS-1:0]                  wr_ready_o,
    output logic [N_PORTS-1:0]                  wr_ack_o
);
    logic [N_PORTS-1:0] rd_gnt, wr_gnt;
    logic [PID_W-1:0]   rd_idx, wr_idx;
    logic               rd_cyc, wr_cyc;
    line_data_t         ram_dout;
    rd_trk_t            rd_trk_d, rd_trk_q;
    wr_trk_t            wr_trk_d, wr_trk_q;
    logic               fwd;
    line_data_t         rsp1_data;
    logic               out_valid;
    port_idx_t          out_pid;
    line_data_t         out_data;

    rr_arbiter #(.N(N_PORTS)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_valid_i),
        .advance_i (rd_cyc),
        .gnt_o     (rd_gnt)
    );

    rr_arbiter #(.N(N_PORTS)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (wr_valid_i),
        .advance_i (wr_cyc),
        .gnt_o     (wr_gnt)
    );

    assign rd_ready_o = rst ? '0 : rd_gnt;
    assign wr_ready_o = rst ? '0 : wr_gnt;
    assign rd_cyc     = |rd_ready_o;
    assign wr_cyc     = |wr_ready_o;
    assign rd_idx     = PID_W'(onehot_to_idx(MAX_PORTS'(rd_gnt)));
    assign wr_idx     = PID_W'(onehot_to_idx(MAX_PORTS'(wr_gnt)));

    always_comb begin
        rd_trk_d       = '0;
        rd_trk_d.valid = rd_cyc;
        rd_trk_d.pid   = port_idx_t'(rd_idx);
        rd_trk_d.addr  = rd_addr_i[rd_idx];
        wr_trk_d       = '0;
        wr_trk_d.valid = wr_cyc;
        wr_trk_d.pid   = port_idx_t'(wr_idx);
        wr_trk_d.addr  = wr_addr_i[wr_idx];
        wr_trk_d.data  = wr_data_i[wr_idx];
    end

    dp_ram_clk #(.AW(MAIN_MEM_AW), .DW(MAIN_MEM_DW)) u_ram (
        .clk      (clk),
        .cyc_a_i  (rd_cyc),
        .addr_a_i (rd_trk_d.addr),
        .dout_a_o (ram_dout),
        .cyc_b_i  (wr_cyc),
        .we_b_i   (wr_cyc),
        .addr_b_i (wr_trk_d.addr),
        .din_b_i  (wr_trk_d.data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_trk_q <= '0;
            wr_trk_q <= '0;
        end else begin
            rd_trk_q <= rd_trk_d;
            wr_trk_q <= wr_trk_d;
        end
    end

    // Write-first: a write to the same line in the grant cycle overrides the RAM's old data.
    assign fwd       = rd_trk_q.valid && wr_trk_q.valid && (rd_trk_q.addr == wr_trk_q.addr);
    assign rsp1_data = !rd_trk_q.valid ? '0 : (fwd ? wr_trk_q.data : ram_dout);
    assign wr_ack_o  = wr_trk_q.valid ? (N_PORTS'(1) << wr_trk_q.pid) : '0;

    if (RD_LAT == 2) begin : g_lat2
        logic       rsp_v_q;
        port_idx_t  rsp_pid_q;
        line_data_t rsp_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_v_q    <= 1'b0;
                rsp_pid_q  <= '0;
                rsp_data_q <= '0;
            end else begin
                rsp_v_q    <= rd_trk_q.valid;
                rsp_pid_q  <= rd_trk_q.pid;
                rsp_data_q <= rsp1_data;
            end
        end

        assign out_valid = rsp_v_q;
        assign out_pid   = rsp_pid_q;
        assign out_data  = rsp_data_q;
    end else begin : g_lat1
        assign out_valid = rd_trk_q.valid;
        assign out_pid   = rd_trk_q.pid;
        assign out_data  = rsp1_data;
    end

    assign rd_rsp_valid_o = out_valid ? (N_PORTS'(1) << out_pid) : '0;
    assign rd_rsp_data_o  = out_data;

endmodule

// File: tb/tb_main_mem_mp.sv
// Bench for main_mem_mp: RD_LAT=2 and RD_LAT=1 instances share stimulus; a cycle model
// of arbitration, memory contents and response timing is compared against both every cycle.
module tb_main_mem_mp;
    import main_mem_mp_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]        rd_valid;
    logic [N-1:0][7:0]   rd_addr;
    logic [N-1:0]        wr_valid;
    logic [N-1:0][7:0]   wr_addr;
    logic [N-1:0][63:0]  wr_data;

    logic [N-1:0] rd_ready2, rd_rsp_valid2, wr_ready2, wr_ack2;
    logic [63:0]  rd_rsp_data2;
    logic [N-1:0] rd_ready1, rd_rsp_valid1, wr_ready1, wr_ack1;
    logic [63:0]  rd_rsp_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_mem_mp #(.N_PORTS(N), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready2),
        .rd_rsp_valid_o(rd_rsp_valid2), .rd_rsp_data_o(rd_rsp_data2),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready2), .wr_ack_o(wr_ack2)
    );

    main_mem_mp #(.N_PORTS(N), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready1),
        .rd_rsp_valid_o(rd_rsp_valid1), .rd_rsp_data_o(rd_rsp_data1),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready1), .wr_ack_o(wr_ack1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mem_m [256];
    bit          rg_v    [int];
    int          rg_pid  [int];
    logic [63:0] rg_data [int];
    bit          wg_v    [int];
    int          wg_pid  [int];
    int cyc    = 0;
    int m_rptr = N - 1;
    int m_wptr = N - 1;
    int rg, wg;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 1; i <= N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic check_rsp(input string tag, input int lat, input logic [N-1:0] v, input logic [63:0] d);
        int key;
        key = cyc - lat;
        if (rg_v.exists(key)) begin
            check({tag, " rsp valid"}, 64'(v), 64'(1) << rg_pid[key]);
            check({tag, " rsp data"}, d, rg_data[key]);
        end else begin
            check({tag, " rsp valid"}, 64'(v), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_rptr = N - 1;
            m_wptr = N - 1;
            rg_v.delete(); rg_pid.delete(); rg_data.delete();
            wg_v.delete(); wg_pid.delete();
            check("rst rd_ready L2", 64'(rd_ready2), 0);
            check("rst wr_ready L2", 64'(wr_ready2), 0);
            check("rst rsp_valid L2", 64'(rd_rsp_valid2), 0);
            check("rst rsp_data L2", rd_rsp_data2, 0);
            check("rst wr_ack L2", 64'(wr_ack2), 0);
            check("rst rd_ready L1", 64'(rd_ready1), 0);
            check("rst wr_ready L1", 64'(wr_ready1), 0);
            check("rst rsp_valid L1", 64'(rd_rsp_valid1), 0);
            check("rst rsp_data L1", rd_rsp_data1, 0);
            check("rst wr_ack L1", 64'(wr_ack1), 0);
        end else begin
            rg = rr_pick(rd_valid, m_rptr);
            wg = rr_pick(wr_valid, m_wptr);
            check("model rd_ready L2", 64'(rd_ready2), (rg >= 0) ? (64'(1) << rg) : 64'd0);
            check("model rd_ready L1", 64'(rd_ready1), (rg >= 0) ? (64'(1) << rg) : 64'd0);
            check("model wr_ready L2", 64'(wr_ready2), (wg >= 0) ? (64'(1) << wg) : 64'd0);
            check("model wr_ready L1", 64'(wr_ready1), (wg >= 0) ? (64'(1) << wg) : 64'd0);
            check_rsp("model L2", 2, rd_rsp_valid2, rd_rsp_data2);
            check_rsp("model L1", 1, rd_rsp_valid1, rd_rsp_data1);
            check("model wr_ack L2", 64'(wr_ack2), wg_v.exists(cyc - 1) ? (64'(1) << wg_pid[cyc - 1]) : 64'd0);
            check("model wr_ack L1", 64'(wr_ack1), wg_v.exists(cyc - 1) ? (64'(1) << wg_pid[cyc - 1]) : 64'd0);
            if (rg >= 0) begin
                rg_v[cyc]    = 1'b1;
                rg_pid[cyc]  = rg;
                rg_data[cyc] = (wg >= 0 && wr_addr[wg] == rd_addr[rg]) ? wr_data[wg] : mem_m[rd_addr[rg]];
                m_rptr = rg;
            end
            if (wg >= 0) begin
                wg_v[cyc]   = 1'b1;
                wg_pid[cyc] = wg;
                mem_m[wr_addr[wg]] = wr_data[wg];
                m_wptr = wg;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int  n;
    bit  done;
    bit  got0;

    initial begin
        foreach (mem_m[i]) mem_m[i] = '0;
        rst = 1'b1;
        rd_valid = '0; rd_addr = '0;
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin reads: both ports valid for 4 cycles.
        rd_valid = 2'b11; rd_addr[0] = 8'h01; rd_addr[1] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr grant", 64'(rd_ready2), (i % 2 == 1) ? 64'h2 : 64'h1);
            check("rr rsp order L1", 64'(rd_rsp_valid1),
                  (i == 0) ? 64'h0 : (((i - 1) % 2 == 1) ? 64'h2 : 64'h1));
            @(posedge clk); #1;
        end
        rd_valid = '0;
        repeat (3) begin @(posedge clk); #1; end

        // Single write then read on port 0.
        wr_valid = 2'b01; wr_addr[0] = 8'h10; wr_data[0] = {8{8'hA5}};
        @(negedge clk);
        check("t1 wr grant", 64'(wr_ready2), 64'h1);
        @(posedge clk); #1;
        wr_valid = '0; rd_valid = 2'b01; rd_addr[0] = 8'h10;
        @(negedge clk);
        check("t1 wr ack", 64'(wr_ack2), 64'h1);
        check("t1 rd grant", 64'(rd_ready2), 64'h1);
        @(posedge clk); #1;
        rd_valid = '0;
        @(negedge clk);
        check("t1 rsp valid L1", 64'(rd_rsp_valid1), 64'h1);
        check("t1 rsp data L1", rd_rsp_data1, {8{8'hA5}});
        @(negedge clk);
        check("t1 rsp valid L2", 64'(rd_rsp_valid2), 64'h1);
        check("t1 rsp data L2", rd_rsp_data2, {8{8'hA5}});
        @(posedge clk); #1;

        // Same-cycle forwarding: port 1 writes 0x20 while port 0 reads 0x20.
        wr_valid = 2'b10; wr_addr[1] = 8'h20; wr_data[1] = {8{8'h5A}};
        rd_valid = 2'b01; rd_addr[0] = 8'h20;
        @(negedge clk);
        check("fwd rd grant", 64'(rd_ready2), 64'h1);
        check("fwd wr grant", 64'(wr_ready2), 64'h2);
        @(posedge clk); #1;
        rd_valid = '0; wr_valid = '0;
        @(negedge clk);
        check("fwd data L1", rd_rsp_data1, {8{8'h5A}});
        @(negedge clk);
        check("fwd data L2", rd_rsp_data2, {8{8'h5A}});
        @(posedge clk); #1;

        // Concurrent read and write to different lines.
        rd_valid = 2'b10; rd_addr[1] = 8'h10;
        wr_valid = 2'b01; wr_addr[0] = 8'h30; wr_data[0] = 64'h1234_5678_9abc_def0;
        @(negedge clk);
        check("conc rd grant", 64'(rd_ready2), 64'h2);
        check("conc wr grant", 64'(wr_ready2), 64'h1);
        @(posedge clk); #1;
        rd_valid = '0; wr_valid = '0;
        @(negedge clk);
        check("conc wr ack", 64'(wr_ack1), 64'h1);
        check("conc old data L1", rd_rsp_data1, {8{8'hA5}});
        @(posedge clk); #1;

        // Held request: port 1 keeps its read valid while port 0 wins first.
        rd_valid = 2'b11; rd_addr[0] = 8'h20; rd_addr[1] = 8'h30;
        n = 0; done = 1'b0;
        while (!done && n < 4 * N) begin
            @(negedge clk);
            n++;
            if (n == 1) check("held first winner", 64'(rd_ready2), 64'h1);
            got0 = rd_ready2[0];
            if (rd_ready2[1]) done = 1'b1;
            @(posedge clk); #1;
            if (got0) rd_valid[0] = 1'b0;
            if (done) rd_valid[1] = 1'b0;
        end
        check("held granted within N_PORTS", (done && n <= N) ? 64'h1 : 64'h0, 64'h1);
        rd_valid = '0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset one cycle after a read grant.
        rd_valid = 2'b01; rd_addr[0] = 8'h10;
        @(negedge clk);
        check("rstop rd grant", 64'(rd_ready2), 64'h1);
        @(posedge clk); #1;
        rd_valid = '0; rst = 1'b1;
        @(negedge clk);
        check("rstop no rsp L2", 64'(rd_rsp_valid2), 64'h0);
        check("rstop data L2", rd_rsp_data2, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_valid = 2'b11; rd_addr[0] = 8'h10; rd_addr[1] = 8'h20;
        wr_valid = 2'b11; wr_addr[0] = 8'h40; wr_addr[1] = 8'h41;
        wr_data[0] = 64'h0000_0000_0000_0040; wr_data[1] = 64'h0000_0000_0000_0041;
        @(negedge clk);
        check("post-rst no stale rsp", 64'(rd_rsp_valid2), 64'h0);
        check("post-rst rd port0 first", 64'(rd_ready2), 64'h1);
        check("post-rst wr port0 first", 64'(wr_ready2), 64'h1);
        @(posedge clk); #1;
        rd_valid = 2'b10; wr_valid = 2'b10;
        @(negedge clk);
        check("post-rst rd port1 next", 64'(rd_ready2), 64'h2);
        @(posedge clk); #1;
        rd_valid = '0; wr_valid = '0;
        repeat (4) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
